morse_decoder: RTL and testbench
================================

Name: morse_decoder

Overview:
- Receive-side counterpart of the Morse letter transmitter. Samples a single key/light input, times each mark and space in units of COUNT_VAL clocks, and classifies each mark as a dot or a dash.
- Collects up to 4 symbols per letter. When the inter-letter gap is seen, decodes the collected symbols to the 3-bit letter code for A–H, the same code space as the switch input of the transmitter.
- Sits between the key/receiver pin and the display/HEX logic.

Parameters:
- COUNT_VAL, 9: clocks per Morse unit (set to 25_000_000 on the board).
- CNT_W, 25: prescaler width; must hold COUNT_VAL-1.
- DASH_UNITS, 2: a mark with at least this many completed units is a dash; fewer is a dot.
- GAP_UNITS, 3: completed space units that end a letter.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- key_in, input, 1: async key/light level; 1 = mark.
- ltr_valid, output, 1: one-cycle pulse; letter result is valid.
- ltr_code, output, 3: decoded letter, A=000 … H=111; held until the next ltr_valid.
- ltr_err, output, 1: qualifies ltr_valid; pattern unmatched or more than 4 symbols.
- sym_len, output, 3: symbols collected so far in the current letter (0–4).
- busy, output, 1: high when state != IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, sync FFs 0, prescaler 0, units 0, sym_bits 0, overflow 0. Reset mid-letter discards the partial letter; no ltr_valid is issued.
- Input conditioning: key_in passes through 2 FFs to give key_s, plus a delay FF key_d.
  - rise = key_s & ~key_d
  - fall = ~key_s & key_d
- Prescaler: counts 0..COUNT_VAL-1 in MARK and SPACE.
  - tick = (prescaler == COUNT_VAL-1).
  - On tick, prescaler wraps to 0 and units increments, saturating at 7.
  - Prescaler and units are cleared on every state entry to MARK or SPACE.
- Symbol register: sym_bits[3:0] shifts left, new symbol into bit0, 1 = dash. sym_len counts symbols.
  - A 5th or later symbol sets overflow; sym_bits and sym_len are unchanged.
- States and transitions:
  - IDLE: rise → MARK.
  - MARK: fall → classify (dot if units < DASH_UNITS, else dash), shift the symbol in, → SPACE.
  - SPACE:
    - rise → MARK (next symbol).
    - tick with units == GAP_UNITS-1 → DECODE.
    - rise wins if both occur in the same cycle.
  - DECODE (exactly 1 cycle): registers the result. Next state is MARK if rise, else IDLE. Also clears sym_bits, sym_len and overflow.
- Decode table, as (sym_len, sym_bits):

  | Letter | Pattern | sym_len | sym_bits |
  |---|---|---|---|
  | A | .- | 2 | 01 |
  | B | -... | 4 | 1000 |
  | C | -.-. | 4 | 1010 |
  | D | -.. | 3 | 100 |
  | E | . | 1 | 0 |
  | F | ..-. | 4 | 0010 |
  | G | --. | 3 | 110 |
  | H | .... | 4 | 0000 |

  - Any other pattern, or overflow set: ltr_err=1, ltr_code=000.
- Latency: count the first clk edge that samples key_in low after the final mark as edge 1. ltr_valid is high during the cycle after edge GAP_UNITS*COUNT_VAL+4 (edge 31 with defaults), for exactly 1 cycle.
- Mark timing: a mark held for k*COUNT_VAL clocks (synchronised) gives units = k at fall.
- A mark never released keeps the FSM in MARK indefinitely, with units saturated at 7; no timeout.

Optional Feature:
- Macro: MORSE_DEC_GLITCH_FILTER_EN.
- Defined: a mark that falls with units == 0 (shorter than 1 unit) is discarded.
  - sym_bits and sym_len are unchanged.
  - The FSM returns to IDLE if sym_len == 0, else to SPACE.
  - The SPACE prescaler and units restart from 0.
- Undefined: a mark with units == 0 is classified as a dot.

Test Plan (COUNT_VAL=9, DASH_UNITS=2, GAP_UNITS=3):
- A: mark 9 clk, space 9, mark 27, then release → ltr_valid 1 cycle at edge 31 after release; ltr_code=000, ltr_err=0; sym_len back to 0.
- H then E back-to-back:
  - Stimulus: four 9-clk marks with 9-clk spaces; 27+ clk space; one 9-clk mark; release.
  - Response: ltr_code=111 then 100, two separate ltr_valid pulses, both with ltr_err=0.
- Overflow: five 9-clk marks → ltr_valid with ltr_err=1, ltr_code=000.
- Unmatched: dash-dash (two 27-clk marks) → ltr_err=1.
- Reset_n low mid-letter, after 2 symbols, then 40 idle clocks → no ltr_valid; busy=0; sym_len=0.
- 3-clk glitch mark followed by idle:
  - Without MORSE_DEC_GLITCH_FILTER_EN: E decoded, ltr_code=100.
  - With MORSE_DEC_GLITCH_FILTER_EN: no ltr_valid; busy=0 within 3 clocks of release.

Source files
------------

// File: rtl/morse_decoder.sv
// morse_decoder
// Receive side of the Morse letter link. A single key/light level is
// synchronised, each mark and space is timed in units of COUNT_VAL clocks,
// marks are classified as dot or dash, and up to four symbols are collected
// per letter. When a space reaches GAP_UNITS units, the collected pattern is
// decoded to the 3-bit A..H letter code used by the transmitter's switches.
//
// Optional build macro: MORSE_DEC_GLITCH_FILTER_EN
//   defined   - a mark shorter than one unit is discarded. The FSM goes back
//               to IDLE when no symbols are held, otherwise to SPACE with a
//               fresh space count.
//   undefined - a mark shorter than one unit is classified as a dot.
//
// Output protocol: ltr_valid is a one-cycle strobe with no ready/back-pressure.
// ltr_code and ltr_err are valid while ltr_valid is high. ltr_code holds its
// value until the next strobe, so a slow consumer may also read it late.
// The FSM state is held in 'state' (type state_t), and busy mirrors state != IDLE.

module morse_decoder #(
  parameter int COUNT_VAL  = 9,
  parameter int CNT_W      = 25,
  parameter int DASH_UNITS = 2,
  parameter int GAP_UNITS  = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_in,
  output logic       ltr_valid,
  output logic [2:0] ltr_code,
  output logic       ltr_err,
  output logic [2:0] sym_len,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MARK   = 2'd1,
    SPACE  = 2'd2,
    DECODE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TICK_VAL = CNT_W'(COUNT_VAL - 1);
  localparam logic [2:0]       DASH_U   = 3'(DASH_UNITS);
  localparam logic [2:0]       GAP_LAST = 3'(GAP_UNITS - 1);
  localparam logic [2:0]       UNITS_MAX = 3'd7;
  localparam logic [2:0]       SYM_MAX  = 3'd4;

  state_t           state;
  logic             key_meta;
  logic             key_s;
  logic             key_d;
  logic [CNT_W-1:0] presc;
  logic [2:0]       units;
  logic [3:0]       sym_bits;
  logic             overflow;

  logic             rise;
  logic             fall;
  logic             timing;
  logic             tick;
  logic [2:0]       units_sat_inc;
  logic [2:0]       units_eff;
  logic             is_dash;
  logic             is_glitch;
  logic [3:0]       sym_bits_nxt;
  logic [2:0]       sym_len_nxt;
  logic             overflow_nxt;
  logic [2:0]       dec_code;
  logic             dec_err;

  // Two-flop synchroniser for the asynchronous key, plus a delay flop for edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_meta <= 1'b0;
      key_s    <= 1'b0;
      key_d    <= 1'b0;
    end else begin
      key_meta <= key_in;
      key_s    <= key_meta;
      key_d    <= key_s;
    end
  end

  assign rise = key_s & ~key_d;
  assign fall = ~key_s & key_d;

  // Unit timing: the prescaler only runs while a mark or space is being timed
  always_comb begin
    timing        = (state == MARK) || (state == SPACE);
    tick          = timing && (presc == TICK_VAL);
    units_sat_inc = (units == UNITS_MAX) ? UNITS_MAX : units + 3'd1;
    // The unit completing on this very cycle counts toward the mark length,
    // so a mark of k*COUNT_VAL clocks is seen as exactly k units.
    units_eff     = tick ? units_sat_inc : units;
    is_dash       = (units_eff >= DASH_U);
    is_glitch     = (units_eff == 3'd0);
  end

  // Symbol accumulation: shift the new symbol in, or flag overflow past four
  always_comb begin
    sym_bits_nxt = sym_bits;
    sym_len_nxt  = sym_len;
    overflow_nxt = overflow;
    if (sym_len >= SYM_MAX) begin
      overflow_nxt = 1'b1;
    end else begin
      sym_bits_nxt = {sym_bits[2:0], is_dash};
      sym_len_nxt  = sym_len + 3'd1;
    end
  end

  // Letter lookup on (symbol count, symbol bits); 1 = dash, latest in bit 0
  always_comb begin
    dec_code = 3'b000;
    dec_err  = 1'b0;
    if (overflow) begin
      dec_err = 1'b1;
    end else begin
      case ({sym_len, sym_bits})
        {3'd2, 4'b0001}: dec_code = 3'd0; // A .-
        {3'd4, 4'b1000}: dec_code = 3'd1; // B -...
        {3'd4, 4'b1010}: dec_code = 3'd2; // C -.-.
        {3'd3, 4'b0100}: dec_code = 3'd3; // D -..
        {3'd1, 4'b0000}: dec_code = 3'd4; // E .
        {3'd4, 4'b0010}: dec_code = 3'd5; // F ..-.
        {3'd3, 4'b0110}: dec_code = 3'd6; // G --.
        {3'd4, 4'b0000}: dec_code = 3'd7; // H ....
        default:         dec_err  = 1'b1;
      endcase
    end
  end

  // Main FSM: state, unit timers, symbol register and registered letter outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      presc     <= '0;
      units     <= 3'd0;
      sym_bits  <= 4'd0;
      sym_len   <= 3'd0;
      overflow  <= 1'b0;
      ltr_valid <= 1'b0;
      ltr_code  <= 3'd0;
      ltr_err   <= 1'b0;
    end else begin
      ltr_valid <= 1'b0;

      if (timing) begin
        if (tick) begin
          presc <= '0;
          units <= units_sat_inc;
        end else begin
          presc <= presc + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (rise) begin
            state <= MARK;
            presc <= '0;
            units <= 3'd0;
          end
        end

        MARK: begin
          if (fall) begin
            presc <= '0;
            units <= 3'd0;
`ifdef MORSE_DEC_GLITCH_FILTER_EN
            if (is_glitch) begin
              // Sub-unit pulse: drop it; resume timing the space if a letter is open
              state <= (sym_len == 3'd0) ? IDLE : SPACE;
            end else begin
              state    <= SPACE;
              sym_bits <= sym_bits_nxt;
              sym_len  <= sym_len_nxt;
              overflow <= overflow_nxt;
            end
`else
            state    <= SPACE;
            sym_bits <= sym_bits_nxt;
            sym_len  <= sym_len_nxt;
            overflow <= overflow_nxt;
`endif
          end
        end

        SPACE: begin
          // A new mark takes priority over the gap expiring on the same cycle
          if (rise) begin
            state <= MARK;
            presc <= '0;
            units <= 3'd0;
          end else if (tick && (units == GAP_LAST)) begin
            state <= DECODE;
          end
        end

        DECODE: begin
          ltr_valid <= 1'b1;
          ltr_code  <= dec_code;
          ltr_err   <= dec_err;
          sym_bits  <= 4'd0;
          sym_len   <= 3'd0;
          overflow  <= 1'b0;
          presc     <= '0;
          units     <= 3'd0;
          state     <= rise ? MARK : IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifndef MORSE_DEC_GLITCH_FILTER_EN
  // Without the filter a sub-unit mark is simply a dot; is_glitch is unused.
  logic unused_glitch;
  assign unused_glitch = is_glitch;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder
// Directed and randomised letters for morse_decoder (COUNT_VAL=9,
// DASH_UNITS=2, GAP_UNITS=3). Expected letters come from a pattern-string
// model: each mark length is turned into '.' or '-', and the resulting string
// is looked up in the A..H table.

module tb_morse_decoder;

  localparam int COUNT_VAL = 9;

  logic       clk;
  logic       reset_n;
  logic       key_in;
  logic       ltr_valid;
  logic [2:0] ltr_code;
  logic       ltr_err;
  logic [2:0] sym_len;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard entries are {err, code}
  logic [3:0] exp_q[$];
  logic [3:0] exp_e;
  logic [2:0] last_code;
  logic       prev_valid;

  string pats[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

  morse_decoder #(
    .COUNT_VAL (COUNT_VAL),
    .CNT_W     (25),
    .DASH_UNITS(2),
    .GAP_UNITS (3)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .key_in   (key_in),
    .ltr_valid(ltr_valid),
    .ltr_code (ltr_code),
    .ltr_err  (ltr_err),
    .sym_len  (sym_len),
    .busy     (busy)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: mark length in clocks -> symbol
  function automatic string sym_of(input int d);
    int u;
    u = d / COUNT_VAL;
    if (u > 7) u = 7;
    return (u >= 2) ? "-" : ".";
  endfunction

  // Reference model: symbol string -> {err, code}
  function automatic logic [3:0] model(input string pat);
    if (pat.len() > 4) return 4'b1000;
    for (int i = 0; i < 8; i++)
      if (pat == pats[i]) return {1'b0, 3'(i)};
    return 4'b1000;
  endfunction

  // Drivers: inputs change on the falling edge
  task automatic mark(input int d);
    key_in = 1'b1;
    repeat (d) @(negedge clk);
    key_in = 1'b0;
  endtask

  task automatic space(input int d);
    key_in = 1'b0;
    repeat (d) @(negedge clk);
  endtask

  // sp == 0 picks a random intra-letter space per gap
  task automatic send_letter(input int n, input int d[5], input int sp, input int gap);
    string pat;
    pat = "";
    for (int i = 0; i < n; i++) pat = {pat, sym_of(d[i])};
    exp_q.push_back(model(pat));
    for (int i = 0; i < n; i++) begin
      mark(d[i]);
      if (i < n - 1) space((sp == 0) ? int'($urandom_range(1, 20)) : sp);
    end
    space(gap);
  endtask

  // Scoreboard monitor: every strobe pops one expected letter
  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      prev_valid = 1'b0;
      last_code  = 3'd0;
    end else begin
      if (ltr_valid === 1'b1) begin
        check("valid_one_cycle", {31'd0, prev_valid}, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {31'd0, ltr_valid}, 0);
        end else begin
          exp_e = exp_q.pop_front();
          check("ltr_err", {31'd0, ltr_err}, {31'd0, exp_e[3]});
          check("ltr_code", {29'd0, ltr_code}, {29'd0, exp_e[2:0]});
        end
        last_code = ltr_code;
      end else if (ltr_code !== last_code) begin
        check("code_hold", {29'd0, ltr_code}, {29'd0, last_code});
      end
      prev_valid = ltr_valid;
    end
  end

  initial begin
    int n;
    int d[5];
    reset_n = 1'b1;
    key_in  = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, ltr_valid}, 0);
    check("rst_code", {29'd0, ltr_code}, 0);
    check("rst_err", {31'd0, ltr_err}, 0);
    check("rst_sym_len", {29'd0, sym_len}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    reset_n = 1'b1;
    space(5);

    // A with exact latency: dot 9, space 9, dash 27
    exp_q.push_back({1'b0, 3'b000});
    mark(9);
    space(9);
    check("a_busy_in_mark", {31'd0, busy}, 1);
    mark(27);
    check("a_sym_len_1", {29'd0, sym_len}, 1);
    repeat (30) @(negedge clk);
    check("a_valid_early", {31'd0, ltr_valid}, 0);
    check("a_sym_len_2", {29'd0, sym_len}, 2);
    @(negedge clk);
    check("a_valid_edge31", {31'd0, ltr_valid}, 1);
    check("a_sym_len_clr", {29'd0, sym_len}, 0);
    @(negedge clk);
    check("a_valid_drop", {31'd0, ltr_valid}, 0);
    check("a_busy_idle", {31'd0, busy}, 0);
    space(5);

    // H then E back to back
    d = '{9, 9, 9, 9, 0};
    send_letter(4, d, 9, 35);
    d = '{9, 0, 0, 0, 0};
    send_letter(1, d, 9, 40);

    // Five dots overflow
    d = '{9, 9, 9, 9, 9};
    send_letter(5, d, 9, 40);

    // Dash-dash is not a letter
    d = '{27, 27, 0, 0, 0};
    send_letter(2, d, 9, 40);

    // Dot/dash boundary: 17 clocks is a dot, 18 a dash -> A
    d = '{17, 18, 0, 0, 0};
    send_letter(2, d, 5, 40);

    // Very long single mark saturates units; lone dash is unmatched
    d = '{100, 0, 0, 0, 0};
    send_letter(1, d, 5, 40);

    // Reset mid-letter after two symbols discards the letter
    mark(9);
    space(9);
    mark(27);
    space(5);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_sym_len", {29'd0, sym_len}, 0);
    check("midrst_valid", {31'd0, ltr_valid}, 0);
    reset_n = 1'b1;
    space(40);
    check("postrst_busy", {31'd0, busy}, 0);
    check("postrst_sym_len", {29'd0, sym_len}, 0);

    // Three-clock glitch mark
`ifdef MORSE_DEC_GLITCH_FILTER_EN
    mark(3);
    repeat (3) @(negedge clk);
    check("glitch_busy", {31'd0, busy}, 0);
    space(40);
`else
    exp_q.push_back({1'b0, 3'b100});
    mark(3);
    space(40);
`endif
    check("glitch_sym_len", {29'd0, sym_len}, 0);

    // Randomised letters, including unmatched and overflowing patterns
    for (int k = 0; k < 14; k++) begin
      n = int'($urandom_range(1, 5));
      for (int j = 0; j < 5; j++)
        d[j] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(18, 45))
                                           : int'($urandom_range(9, 17));
      send_letter(n, d, 0, int'($urandom_range(32, 50)));
    end

    // Drain with a bounded wait
    for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    check("final_busy", {31'd0, busy}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
